// File: rtl/aim_neuron_seq_pkg.sv
// Shared types and helpers for the folded ternary-weight neuron (package aim_pkg).
// Weight codes, FSM state encoding and the saturating clip function.
package aim_pkg;

  localparam logic [1:0] W_POS  = 2'b01;
  localparam logic [1:0] W_NEG  = 2'b11;
  localparam logic [1:0] W_ZERO = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Clip a signed value into the range of a signed word of the given width.
  function automatic logic signed [31:0] sat_to(input logic signed [31:0] v, input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (v > hi) begin
      sat_to = hi;
    end else if (v < lo) begin
      sat_to = lo;
    end else begin
      sat_to = v;
    end
  endfunction

endpackage

// File: rtl/aim_neuron_seq_if.sv
// Vector-in / result-out handshake bundle for aim_neuron_seq.
// slave is the neuron's view, master is the producer/consumer view.
interface aim_neuron_seq_if #(
  parameter int N     = 8,
  parameter int A_W   = 9,
  parameter int OUT_W = 12
);
  logic                    in_valid;
  logic                    in_ready;
  logic [N*A_W-1:0]        A_bus;
  logic [2*N-1:0]          W_bus;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_neuron;
  logic                    out_sat;

  modport slave (
    input  in_valid, A_bus, W_bus, out_ready,
    output in_ready, out_valid, out_neuron, out_sat
  );

  modport master (
    output in_valid, A_bus, W_bus, out_ready,
    input  in_ready, out_valid, out_neuron, out_sat
  );
endinterface

// File: rtl/aim_neuron_seq_lane_mac.sv
// Combinational ternary multiply and sum across LANES activations.
// Lane sum width A_W+$clog2(LANES)+1 holds the worst case -(-2^(A_W-1)) per lane.
module aim_lane_mac
  import aim_pkg::*;
#(
  parameter int LANES = 2,
  parameter int A_W   = 9
) (
  input  logic [LANES*A_W-1:0]            a_i,
  input  logic [2*LANES-1:0]              w_i,
  output logic signed [A_W+$clog2(LANES):0] sum_o
);

  localparam int SUM_W = A_W + $clog2(LANES) + 1;

  logic signed [A_W-1:0]   aLane;
  logic signed [SUM_W-1:0] prod;
  logic signed [SUM_W-1:0] sum;

  // Reserved code 2'b10 falls into the default arm and contributes nothing.
  always_comb begin
    aLane = '0;
    prod  = '0;
    sum   = '0;
    for (int l = 0; l < LANES; l++) begin
      aLane = a_i[l*A_W +: A_W];
      case (w_i[2*l +: 2])
        W_POS:   prod = SUM_W'(aLane);
        W_NEG:   prod = -SUM_W'(aLane);
        default: prod = '0;
      endcase
      sum = sum + prod;
    end
  end

  assign sum_o = sum;

endmodule

// File: rtl/aim_neuron_seq.sv
// Folded ternary-weight neuron: LANES products per cycle over N/LANES cycles, saturated output.
// Build option AIM_RELU_EN: negative results are forced to zero with out_sat cleared.
module aim_neuron_seq
  import aim_pkg::*;
#(
  parameter int N     = 8,
  parameter int LANES = 2,
  parameter int A_W   = 9,
  parameter int OUT_W = 12
) (
  input logic              clk,
  input logic              rst,
  aim_neuron_seq_if.slave  bus
);

  localparam int CHUNKS = N / LANES;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int ACC_W  = A_W + $clog2(N) + 1;
  localparam int SUM_W  = A_W + $clog2(LANES) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNKS - 1);

  state_e                  state_q;
  logic [N*A_W-1:0]        opA_q;
  logic [2*N-1:0]          opW_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [OUT_W-1:0] outNeuron_q;
  logic signed [OUT_W-1:0] outNeuron_d;
  logic                    outSat_q;
  logic                    outSat_d;
  logic                    outValid_q;
  logic signed [SUM_W-1:0] laneSum;
  logic signed [31:0]      accWide;
  logic signed [31:0]      satWide;

  // Operand registers shift down one chunk per cycle, so the lane MAC always reads the low bits.
  aim_lane_mac #(
    .LANES (LANES),
    .A_W   (A_W)
  ) u_lane_mac (
    .a_i   (opA_q[LANES*A_W-1:0]),
    .w_i   (opW_q[2*LANES-1:0]),
    .sum_o (laneSum)
  );

  always_comb begin
    acc_d       = acc_q + ACC_W'(laneSum);
    accWide     = 32'(acc_d);
    satWide     = sat_to(accWide, OUT_W);
    outNeuron_d = satWide[OUT_W-1:0];
    outSat_d    = (satWide != accWide);
`ifdef AIM_RELU_EN
    if (acc_d < 0) begin
      outNeuron_d = '0;
      outSat_d    = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      opA_q       <= '0;
      opW_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      outNeuron_q <= '0;
      outSat_q    <= 1'b0;
      outValid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            opA_q   <= bus.A_bus;
            opW_q   <= bus.W_bus;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= ACC;
          end
        end
        ACC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          opA_q <= opA_q >> (LANES*A_W);
          opW_q <= opW_q >> (2*LANES);
          if (cnt_q == LAST_CNT) begin
            outNeuron_q <= outNeuron_d;
            outSat_q    <= outSat_d;
            outValid_q  <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = outValid_q;
  assign bus.out_neuron = outNeuron_q;
  assign bus.out_sat    = outSat_q;

endmodule
